// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-checking sweep of the two-input basic-gate unit.
// Drives (in1,in2) through 00,10,01,11. Each vector is held for
// SETTLE_CYCLES cycles, then gate_out is compared against the ideal truth
// table. Mismatches accumulate into a per-gate mask, a per-vector mask and
// a bit count.
// Optional build macro GATE_SWEEP_HALT_EN: the first vector with a mismatch
// ends the sweep. The failing vector stays on in1/in2 for debug.
//
// state  | meaning
// IDLE   | waiting for start; results and in1/in2 hold
// SETTLE | current vector driven, counting settle cycles
// CHECK  | compare gate_out on this edge, then advance or finish
// DONE   | one-cycle done pulse, pass valid
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] gate_out,
   output logic       in1,
   output logic       in2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] fail_mask,
   output logic [3:0] fail_vec,
   output logic [5:0] mismatch_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [1:0]  vec_q, vec_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        in1_q, in1_d;
   logic        in2_q, in2_d;
   logic        pass_q, pass_d;
   logic [7:0]  fail_mask_q, fail_mask_d;
   logic [3:0]  fail_vec_q, fail_vec_d;
   logic [5:0]  mismatch_cnt_q, mismatch_cnt_d;
   logic [7:0]  exp_out;
   logic [7:0]  err;
   logic        last_vec;

   function automatic logic [7:0] ideal_gates(input logic a, input logic b);
      return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] x);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, x[i]};
      end
      return n;
   endfunction

   // Compare the current vector's outputs against the ideal table.
   always_comb begin
      exp_out = ideal_gates(in1_q, in2_q);
      err     = gate_out ^ exp_out;
`ifdef GATE_SWEEP_HALT_EN
      last_vec = (vec_q == 2'd3) || (err != 8'h00);
`else
      last_vec = (vec_q == 2'd3);
`endif
   end

   // Next-state and register updates for the sweep sequencer.
   always_comb begin
      state_d        = state_q;
      vec_d          = vec_q;
      cnt_d          = cnt_q;
      in1_d          = in1_q;
      in2_d          = in2_q;
      pass_d         = pass_q;
      fail_mask_d    = fail_mask_q;
      fail_vec_d     = fail_vec_q;
      mismatch_cnt_d = mismatch_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               fail_mask_d    = 8'h00;
               fail_vec_d     = 4'h0;
               mismatch_cnt_d = 6'd0;
               pass_d         = 1'b0;
               vec_d          = 2'd0;
               in1_d          = 1'b0;
               in2_d          = 1'b0;
               cnt_d          = 4'd0;
               state_d        = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
               in1_d   = 1'b0;
               in2_d   = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
               in1_d   = 1'b0;
               in2_d   = 1'b0;
            end else begin
               fail_mask_d    = fail_mask_q | err;
               fail_vec_d     = fail_vec_q;
               fail_vec_d[vec_q] = fail_vec_q[vec_q] | (err != 8'h00);
               mismatch_cnt_d = mismatch_cnt_q + {2'b00, popcount8(err)};
               if (last_vec) begin
                  pass_d  = (fail_mask_d == 8'h00);
                  state_d = ST_DONE;
               end else begin
                  vec_d   = vec_q + 2'd1;
                  in1_d   = vec_d[0];
                  in2_d   = vec_d[1];
                  cnt_d   = 4'd0;
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_DONE: begin
            if (abort) begin
               pass_d = 1'b0;
               in1_d  = 1'b0;
               in2_d  = 1'b0;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         vec_q          <= 2'd0;
         cnt_q          <= 4'd0;
         in1_q          <= 1'b0;
         in2_q          <= 1'b0;
         pass_q         <= 1'b0;
         fail_mask_q    <= 8'h00;
         fail_vec_q     <= 4'h0;
         mismatch_cnt_q <= 6'd0;
      end else begin
         state_q        <= state_d;
         vec_q          <= vec_d;
         cnt_q          <= cnt_d;
         in1_q          <= in1_d;
         in2_q          <= in2_d;
         pass_q         <= pass_d;
         fail_mask_q    <= fail_mask_d;
         fail_vec_q     <= fail_vec_d;
         mismatch_cnt_q <= mismatch_cnt_d;
      end
   end

   // An abort that arrives during DONE suppresses the done pulse.
   always_comb begin
      in1          = in1_q;
      in2          = in2_q;
      busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
      done         = (state_q == ST_DONE) && !abort;
      pass         = pass_q;
      fail_mask    = fail_mask_q;
      fail_vec     = fail_vec_q;
      mismatch_cnt = mismatch_cnt_q;
   end

endmodule
